// File: rtl/dsss_pkg.sv
// Shared DSSS receive-chain definitions: sequence length, correlator value
// width and mid-point, synchroniser state encoding and the deviation helper.
package dsss_pkg;

  localparam int SEQ_LEN_DEF = 31;
  localparam int CORR_W      = 8;
  localparam int CORR_MID    = SEQ_LEN_DEF;
  localparam int DEV_W       = 6;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } sync_state_e;

  // Distance of a correlation value from the no-correlation mid point.
  function automatic logic [DEV_W-1:0] corr_dev(input logic [CORR_W-1:0] corr,
                                                input logic [CORR_W-1:0] mid);
    logic [CORR_W-1:0] diff;
    if (corr > mid) begin
      diff = corr - mid;
    end else begin
      diff = mid - corr;
    end
    return DEV_W'(diff);
  endfunction

endpackage

// File: rtl/corr_window_max.sv
// Running maximum of |dev| over one tracking window. Keeps the winning
// deviation, its sign and its position, plus the sign of the centre sample.
// The merged outputs already include the sample presented this cycle, so the
// parent can decide on the window-closing sample itself.
module corr_window_max
  import dsss_pkg::*;
#(
  parameter int WIN   = 1,
  parameter int IDX_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_smp,
  input  logic             i_first,
  input  logic [DEV_W-1:0] i_dev,
  input  logic             i_sign,
  input  logic [IDX_W-1:0] i_idx,
  output logic [DEV_W-1:0] o_dev,
  output logic             o_sign,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_centre_sign
);

  localparam logic [IDX_W-1:0] CENTRE_IDX = IDX_W'(WIN);

  logic [DEV_W-1:0] r_dev;
  logic             r_sign;
  logic [IDX_W-1:0] r_idx;
  logic             r_centre_sign;
  logic             w_is_centre;
  logic             w_take;

  assign w_is_centre = (i_idx == CENTRE_IDX);

  // Current sample wins if it starts the window, is strictly larger, or ties at the centre.
  always_comb begin
    w_take = 1'b0;
    if (i_first) begin
      w_take = 1'b1;
    end else if (i_dev > r_dev) begin
      w_take = 1'b1;
    end else if ((i_dev == r_dev) && w_is_centre) begin
      w_take = 1'b1;
    end else begin
      w_take = 1'b0;
    end
  end

  // Merge the stored winner with the current sample.
  always_comb begin
    o_dev         = r_dev;
    o_sign        = r_sign;
    o_idx         = r_idx;
    o_centre_sign = r_centre_sign;
    if (w_take) begin
      o_dev  = i_dev;
      o_sign = i_sign;
      o_idx  = i_idx;
    end else begin
      o_dev  = r_dev;
      o_sign = r_sign;
      o_idx  = r_idx;
    end
    if (w_is_centre) begin
      o_centre_sign = i_sign;
    end else begin
      o_centre_sign = r_centre_sign;
    end
  end

  // Register the merged winner on every enabled in-window sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dev         <= '0;
      r_sign        <= 1'b0;
      r_idx         <= '0;
      r_centre_sign <= 1'b0;
    end else if (i_smp) begin
      r_dev         <= o_dev;
      r_sign        <= o_sign;
      r_idx         <= o_idx;
      r_centre_sign <= o_centre_sign;
    end else begin
      r_dev         <= r_dev;
      r_sign        <= r_sign;
      r_idx         <= r_idx;
      r_centre_sign <= r_centre_sign;
    end
  end

endmodule

// File: rtl/corr_peak_sync.sv
// Symbol timing acquisition and tracking behind the m-sequence correlator.
// Finds correlation peaks, verifies their spacing, then tracks the peak within
// a +/-WIN window and emits one bit per symbol with erasure and slip flags.
module corr_peak_sync
  import dsss_pkg::*;
#(
  parameter int SEQ_LEN  = SEQ_LEN_DEF,
  parameter int THR      = 21,
  parameter int WIN      = 1,
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_en,
  input  logic [CORR_W-1:0] i_corr_in,
  output logic              o_bit_out,
  output logic              o_bit_valid,
  output logic              o_erasure,
  output logic              o_locked,
  output logic              o_slip_early,
  output logic              o_slip_late
);

  localparam int PH_W = $clog2(SEQ_LEN + WIN + 1);
  localparam int HC_W = $clog2(LOCK_CNT + 1);
  localparam int MC_W = $clog2(MISS_MAX + 1);

  localparam logic [CORR_W-1:0] CORR_MAX  = CORR_W'(2 * SEQ_LEN);
  localparam logic [CORR_W-1:0] MID_V     = CORR_W'(SEQ_LEN);
  localparam logic [DEV_W-1:0]  THR_V     = DEV_W'(THR);
  localparam logic [PH_W-1:0]   PH_START  = PH_W'(SEQ_LEN - WIN);
  localparam logic [PH_W-1:0]   PH_CLOSE  = PH_W'(SEQ_LEN + WIN);
  localparam logic [PH_W-1:0]   CENTRE    = PH_W'(WIN);
  localparam logic [PH_W-1:0]   RB_HIT    = PH_W'(2 * WIN + 1);
  localparam logic [PH_W-1:0]   RB_MISS   = PH_W'(WIN + 1);
  localparam logic [HC_W-1:0]   HIT_LOCK  = HC_W'(LOCK_CNT);
  localparam logic [MC_W-1:0]   MISS_DROP = MC_W'(MISS_MAX);

  sync_state_e       r_state, w_state_nxt;
  logic [PH_W-1:0]   r_ph, w_ph_nxt;
  logic [HC_W-1:0]   r_hit_cnt, w_hit_nxt;
  logic [MC_W-1:0]   r_miss_cnt, w_miss_nxt;
  logic              r_bit_out, w_bit_out_nxt;
  logic              r_bit_valid, w_valid_nxt;
  logic              r_erasure, w_eras_nxt;
  logic              r_locked, w_locked_nxt;
  logic              r_slip_early, w_se_nxt;
  logic              r_slip_late, w_sl_nxt;

  logic [CORR_W-1:0] w_corr;
  logic [DEV_W-1:0]  w_dev;
  logic              w_sign;
  logic              w_in_win;
  logic              w_smp;
  logic              w_first;
  logic              w_close;
  logic [PH_W-1:0]   w_idx;
  logic [DEV_W-1:0]  w_win_dev;
  logic              w_win_sign;
  logic [PH_W-1:0]   w_win_idx;
  logic              w_centre_sign;
  logic              w_hit;
  logic [PH_W-1:0]   w_rebase_hit;

  assign w_corr       = (i_corr_in > CORR_MAX) ? CORR_MAX : i_corr_in;
  assign w_dev        = corr_dev(w_corr, MID_V);
  assign w_sign       = (w_corr > MID_V);
  assign w_in_win     = (r_ph >= PH_START) && (r_ph <= PH_CLOSE);
  assign w_smp        = i_in_en && (r_state != SEARCH) && w_in_win;
  assign w_first      = (r_ph == PH_START);
  assign w_close      = w_smp && (r_ph == PH_CLOSE);
  assign w_idx        = r_ph - PH_START;
  assign w_hit        = (w_win_dev >= THR_V);
  // Winner at window index idx sits WIN-idx chips from centre; next sample is one past it.
  assign w_rebase_hit = RB_HIT - w_win_idx;

  corr_window_max #(
    .WIN   (WIN),
    .IDX_W (PH_W)
  ) u_win (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_smp         (w_smp),
    .i_first       (w_first),
    .i_dev         (w_dev),
    .i_sign        (w_sign),
    .i_idx         (w_idx),
    .o_dev         (w_win_dev),
    .o_sign        (w_win_sign),
    .o_idx         (w_win_idx),
    .o_centre_sign (w_centre_sign)
  );

  // Next-state, phase, counters and output pulses for one enabled sample.
  always_comb begin
    w_state_nxt   = r_state;
    w_ph_nxt      = r_ph;
    w_hit_nxt     = r_hit_cnt;
    w_miss_nxt    = r_miss_cnt;
    w_bit_out_nxt = r_bit_out;
    w_locked_nxt  = r_locked;
    w_valid_nxt   = 1'b0;
    w_eras_nxt    = 1'b0;
    w_se_nxt      = 1'b0;
    w_sl_nxt      = 1'b0;
    if (i_in_en) begin
      case (r_state)
        SEARCH: begin
          if (w_dev >= THR_V) begin
            w_state_nxt = VERIFY;
            w_ph_nxt    = PH_W'(1);
            w_hit_nxt   = HC_W'(1);
          end else begin
            w_ph_nxt  = '0;
            w_hit_nxt = '0;
          end
        end
        VERIFY: begin
          if (w_close) begin
            if (w_hit) begin
              w_ph_nxt  = w_rebase_hit;
              w_hit_nxt = r_hit_cnt + HC_W'(1);
              if ((r_hit_cnt + HC_W'(1)) == HIT_LOCK) begin
                w_state_nxt   = LOCK;
                w_locked_nxt  = 1'b1;
                w_miss_nxt    = '0;
                w_valid_nxt   = 1'b1;
                w_bit_out_nxt = w_win_sign;
              end else begin
                w_state_nxt = VERIFY;
              end
            end else begin
              w_state_nxt = SEARCH;
              w_ph_nxt    = '0;
              w_hit_nxt   = '0;
            end
          end else begin
            w_ph_nxt = r_ph + PH_W'(1);
          end
        end
        LOCK: begin
          if (w_close) begin
            w_valid_nxt = 1'b1;
            if (w_hit) begin
              w_bit_out_nxt = w_win_sign;
              w_miss_nxt    = '0;
              w_ph_nxt      = w_rebase_hit;
              w_se_nxt      = (w_win_idx < CENTRE);
              w_sl_nxt      = (w_win_idx > CENTRE);
            end else begin
              w_bit_out_nxt = w_centre_sign;
              w_eras_nxt    = 1'b1;
              if ((r_miss_cnt + MC_W'(1)) == MISS_DROP) begin
                w_state_nxt  = SEARCH;
                w_locked_nxt = 1'b0;
                w_miss_nxt   = '0;
                w_hit_nxt    = '0;
                w_ph_nxt     = '0;
              end else begin
                w_miss_nxt = r_miss_cnt + MC_W'(1);
                w_ph_nxt   = RB_MISS;
              end
            end
          end else begin
            w_ph_nxt = r_ph + PH_W'(1);
          end
        end
        default: begin
          w_state_nxt  = SEARCH;
          w_ph_nxt     = '0;
          w_hit_nxt    = '0;
          w_miss_nxt   = '0;
          w_locked_nxt = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, counters and registered outputs; pulses self-clear every edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= SEARCH;
      r_ph         <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_erasure    <= 1'b0;
      r_locked     <= 1'b0;
      r_slip_early <= 1'b0;
      r_slip_late  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ph         <= w_ph_nxt;
      r_hit_cnt    <= w_hit_nxt;
      r_miss_cnt   <= w_miss_nxt;
      r_bit_out    <= w_bit_out_nxt;
      r_bit_valid  <= w_valid_nxt;
      r_erasure    <= w_eras_nxt;
      r_locked     <= w_locked_nxt;
      r_slip_early <= w_se_nxt;
      r_slip_late  <= w_sl_nxt;
    end
  end

  assign o_bit_out    = r_bit_out;
  assign o_bit_valid  = r_bit_valid;
  assign o_erasure    = r_erasure;
  assign o_locked     = r_locked;
  assign o_slip_early = r_slip_early;
  assign o_slip_late  = r_slip_late;

endmodule

// File: tb/tb_corr_peak_sync.sv
// Scoreboard bench for corr_peak_sync: a sample-index reference model pushes
// expected symbol events; a negedge monitor pops them whenever the DUT pulses.
module tb_corr_peak_sync;

  localparam int S   = 31;
  localparam int THR = 21;
  localparam int W   = 1;
  localparam int LC  = 3;
  localparam int MM  = 2;

  localparam int M_SEARCH = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCK   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_en = 1'b0;
  logic [7:0] corr = 8'd0;
  logic       bit_out, bit_valid, erasure, locked, slip_early, slip_late;

  typedef struct packed {
    logic bv;
    logic bo;
    logic er;
    logic se;
    logic sl;
    logic lk;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_got, mon_exp;
  int  checks = 0;
  int  errors = 0;

  // reference model state (enabled-sample index arithmetic)
  int m_state, m_n, m_anchor, m_hits, m_misses;
  bit m_locked;
  int win_dev[$];
  int win_pos[$];
  bit win_sgn[$];

  int gap_pct  = 0;
  int noise_lo = 31;
  int noise_hi = 31;

  always #5 clk = ~clk;

  corr_peak_sync #(
    .SEQ_LEN(S), .THR(THR), .WIN(W), .LOCK_CNT(LC), .MISS_MAX(MM)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_en      (in_en),
    .i_corr_in    (corr),
    .o_bit_out    (bit_out),
    .o_bit_valid  (bit_valid),
    .o_erasure    (erasure),
    .o_locked     (locked),
    .o_slip_early (slip_early),
    .o_slip_late  (slip_late)
  );

  function automatic void model_reset();
    m_state  = M_SEARCH;
    m_n      = 0;
    m_anchor = 0;
    m_hits   = 0;
    m_misses = 0;
    m_locked = 1'b0;
    win_dev.delete();
    win_pos.delete();
    win_sgn.delete();
  endfunction

  function automatic void push_ev(bit bo, bit er, bit se, bit sl, bit lk);
    ev_t e;
    e.bv = 1'b1; e.bo = bo; e.er = er; e.se = se; e.sl = sl; e.lk = lk;
    exp_q.push_back(e);
  endfunction

  function automatic void model_step(int v);
    int c, dev, d, best;
    bit sgn, cen_sgn, hit;
    c   = (v > 2 * S) ? 2 * S : v;
    dev = (c > S) ? c - S : S - c;
    sgn = (c > S);
    if (m_state == M_SEARCH) begin
      if (dev >= THR) begin
        m_state  = M_VERIFY;
        m_anchor = m_n;
        m_hits   = 1;
      end
    end else begin
      d = m_n - m_anchor;
      if (d >= S - W && d <= S + W) begin
        win_dev.push_back(dev);
        win_pos.push_back(d - S);
        win_sgn.push_back(sgn);
      end
      if (d == S + W) begin
        best    = 0;
        cen_sgn = 1'b0;
        for (int i = 0; i < win_dev.size(); i++) begin
          if (win_pos[i] == 0) cen_sgn = win_sgn[i];
          if (win_dev[i] > win_dev[best] || (win_dev[i] == win_dev[best] && win_pos[i] == 0))
            best = i;
        end
        hit = (win_dev[best] >= THR);
        if (m_state == M_VERIFY) begin
          if (hit) begin
            m_hits++;
            m_anchor = m_anchor + S + win_pos[best];
            if (m_hits == LC) begin
              m_state  = M_LOCK;
              m_locked = 1'b1;
              m_misses = 0;
              push_ev(win_sgn[best], 1'b0, 1'b0, 1'b0, 1'b1);
            end
          end else begin
            m_state = M_SEARCH;
            m_hits  = 0;
          end
        end else begin
          if (hit) begin
            m_misses = 0;
            m_anchor = m_anchor + S + win_pos[best];
            push_ev(win_sgn[best], 1'b0, win_pos[best] < 0, win_pos[best] > 0, 1'b1);
          end else begin
            m_anchor = m_anchor + S;
            m_misses++;
            if (m_misses == MM) begin
              m_state  = M_SEARCH;
              m_locked = 1'b0;
              m_hits   = 0;
            end
            push_ev(cen_sgn, 1'b1, 1'b0, 1'b0, m_locked);
          end
        end
        win_dev.delete();
        win_pos.delete();
        win_sgn.delete();
      end
    end
    m_n++;
  endfunction

  // one enabled sample, optionally preceded by random disabled cycles
  task automatic send(input int v);
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      @(posedge clk); #1;
      in_en = 1'b0;
      corr  = 8'($urandom_range(255));
    end
    @(posedge clk); #1;
    in_en = 1'b1;
    corr  = 8'(v);
    model_step(v);
  endtask

  task automatic noise(input int k);
    for (int i = 0; i < k; i++) send($urandom_range(noise_hi, noise_lo));
  endtask

  // peak preceded by gap-1 noise samples (gap = spacing from previous peak)
  task automatic peaks(input int v, input int gap);
    noise(gap - 1);
    send(v);
  endtask

  task automatic train(input int n);
    for (int i = 0; i < n; i++) peaks(62, S);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      in_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst   = 1'b1;
    in_en = 1'($urandom_range(1));
    corr  = 8'd62;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({bit_out, bit_valid, erasure, locked, slip_early, slip_late} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=000000",
               {bit_out, bit_valid, erasure, locked, slip_early, slip_late});
    end
    rst   = 1'b0;
    in_en = 1'b0;
  endtask

  task automatic check_locked(input string name);
    idle(2);
    checks++;
    if (locked !== m_locked) begin
      errors++;
      $display("FAIL %s locked got=%b want=%b", name, locked, m_locked);
    end
  endtask

  // monitor: every symbol/slip pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (bit_valid || erasure || slip_early || slip_late) begin
      checks++;
      mon_got = '{bv: bit_valid, bo: bit_out, er: erasure, se: slip_early, sl: slip_late, lk: locked};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got(bv,bo,er,se,sl,lk)=%b want=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL symbol_event got(bv,bo,er,se,sl,lk)=%b want=%b t=%0t", mon_got, mon_exp, $time);
        end
      end
    end
  end

  initial begin
    int v;
    int g;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // clean stream
    train(2);
    check_locked("before_lock");
    train(4);
    check_locked("after_lock");

    // bit pattern, corr=10 accepted, corr=11 missed
    for (int i = 0; i < 6; i++) peaks((i % 2 == 1) ? 62 : 0, S);
    peaks(10, S);
    peaks(11, S);
    train(3);
    check_locked("pattern");

    // drift: early, late, then out-of-window
    peaks(62, 30);
    peaks(62, 32);
    peaks(62, S);
    peaks(62, 33);
    peaks(62, S);
    train(5);
    check_locked("drift_reacq");

    // loss of two peaks in lock
    train(2);
    noise(2 * S);
    check_locked("loss");
    train(4);
    check_locked("loss_reacq");

    // false start into noise
    do_reset();
    noise_lo = 25;
    noise_hi = 37;
    peaks(62, 10);
    noise(100);
    check_locked("false_start");

    // in_en gaps, then reset mid-window
    do_reset();
    noise_lo = 31;
    noise_hi = 31;
    gap_pct  = 30;
    train(6);
    gap_pct  = 0;
    noise(S - 1);
    do_reset();
    train(2);
    check_locked("post_rst_2");
    train(2);
    check_locked("post_rst_4");

    // randomized: jittered spacing, random peak values incl. clamped, dropped peaks
    do_reset();
    gap_pct  = 20;
    noise_lo = 11;
    noise_hi = 51;
    for (int i = 0; i < 40; i++) begin
      g = S + $urandom_range(2) - 1;
      if ($urandom_range(9) == 0) g = S + $urandom_range(4) - 2;
      case ($urandom_range(3))
        0:       v = $urandom_range(10);
        1:       v = $urandom_range(255, 52);
        2:       v = 62;
        default: v = $urandom_range(51, 11);
      endcase
      peaks(v, g);
    end
    gap_pct = 0;
    check_locked("random");

    idle(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
